// File: rtl/dbus_initiator.sv
// Single-outstanding dbus initiator: accepts one request, drives it onto the dbus,
// waits for the responder's ack (or a watchdog timeout) and returns a one-cycle response.
module dbus_initiator #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_i,
  input  logic                    cpu_w_en_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_sel_i,
  output logic                    cpu_ready_o,
  output logic                    cpu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
  output logic                    cpu_err_o,
  output logic                    dbus_req_o,
  output logic                    dbus_w_en_o,
  output logic [ADDR_WIDTH-1:0]   dbus_addr_o,
  output logic [DATA_WIDTH-1:0]   dbus_w_data_o,
  output logic [DATA_WIDTH/8-1:0] dbus_sel_o,
  input  logic                    dbus_ack_i,
  input  logic [DATA_WIDTH-1:0]   dbus_r_data_i
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  // Acks in the first REQ cycle are stale: a registered responder cannot answer that fast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      cpu_ready_o     <= 1'b1;
      cpu_rsp_valid_o <= 1'b0;
      cpu_rdata_o     <= '0;
      cpu_err_o       <= 1'b0;
      dbus_req_o      <= 1'b0;
      dbus_w_en_o     <= 1'b0;
      dbus_addr_o     <= '0;
      dbus_w_data_o   <= '0;
      dbus_sel_o      <= SEL_WIDTH'(0);
    end else begin
      case (state)
        S_IDLE: begin
          cpu_rsp_valid_o <= 1'b0;
          if (cpu_req_i) begin
            state         <= S_REQ;
            cnt           <= '0;
            cpu_ready_o   <= 1'b0;
            dbus_req_o    <= 1'b1;
            dbus_w_en_o   <= cpu_w_en_i;
            dbus_addr_o   <= cpu_addr_i;
            dbus_w_data_o <= cpu_wdata_i;
            dbus_sel_o    <= cpu_sel_i;
          end
        end
        S_REQ: begin
          if (cnt < CNT_WIDTH'(TIMEOUT_CYCLES)) begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
          if (dbus_ack_i && (cnt != '0)) begin
            state           <= S_RESP;
            cpu_rsp_valid_o <= 1'b1;
            cpu_rdata_o     <= dbus_w_en_o ? '0 : dbus_r_data_i;
            cpu_err_o       <= 1'b0;
            dbus_req_o      <= 1'b0;
            dbus_w_en_o     <= 1'b0;
          end else if (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state           <= S_RESP;
            cpu_rsp_valid_o <= 1'b1;
            cpu_rdata_o     <= '0;
            cpu_err_o       <= 1'b1;
            dbus_req_o      <= 1'b0;
            dbus_w_en_o     <= 1'b0;
          end
        end
        S_RESP: begin
          state           <= S_IDLE;
          cpu_rsp_valid_o <= 1'b0;
          cpu_ready_o     <= 1'b1;
        end
        default: begin
          state           <= S_IDLE;
          cpu_rsp_valid_o <= 1'b0;
          cpu_ready_o     <= 1'b1;
          dbus_req_o      <= 1'b0;
          dbus_w_en_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_initiator.sv
// Bench for dbus_initiator: directed and random transactions checked cycle by cycle
// against a latency/result model derived from the ack timing of each transaction.
module tb_dbus_initiator;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_w_en;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_sel;
  logic          cpu_ready_o, cpu_rsp_valid_o, cpu_err_o;
  logic [DW-1:0] cpu_rdata_o;
  logic          dbus_req_o, dbus_w_en_o;
  logic [AW-1:0] dbus_addr_o;
  logic [DW-1:0] dbus_w_data_o;
  logic [3:0]    dbus_sel_o;
  logic          dbus_ack;
  logic [DW-1:0] dbus_r_data;

  int n_cmp = 0;
  int n_err = 0;

  dbus_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_i      (cpu_req),
    .cpu_w_en_i     (cpu_w_en),
    .cpu_addr_i     (cpu_addr),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_sel_i      (cpu_sel),
    .cpu_ready_o    (cpu_ready_o),
    .cpu_rsp_valid_o(cpu_rsp_valid_o),
    .cpu_rdata_o    (cpu_rdata_o),
    .cpu_err_o      (cpu_err_o),
    .dbus_req_o     (dbus_req_o),
    .dbus_w_en_o    (dbus_w_en_o),
    .dbus_addr_o    (dbus_addr_o),
    .dbus_w_data_o  (dbus_w_data_o),
    .dbus_sel_o     (dbus_sel_o),
    .dbus_ack_i     (dbus_ack),
    .dbus_r_data_i  (dbus_r_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, cpu_ready_o, 1);
    chk({tag, "_rsp_valid"}, cpu_rsp_valid_o, 0);
    chk({tag, "_rdata"}, cpu_rdata_o, 0);
    chk({tag, "_err"}, cpu_err_o, 0);
    chk({tag, "_req"}, dbus_req_o, 0);
    chk({tag, "_w_en"}, dbus_w_en_o, 0);
    chk({tag, "_addr"}, dbus_addr_o, 0);
    chk({tag, "_wdata"}, dbus_w_data_o, 0);
    chk({tag, "_sel"}, dbus_sel_o, 0);
  endtask

  // Called at a negedge in IDLE. ack_at = REQ cycle (1-based) in which ack is driven, 0 = never.
  // The response arrives one cycle after a legal ack (REQ cycle 2..T), otherwise after T REQ cycles.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [3:0] sel, input int ack_at, input logic [DW-1:0] rd,
                     input bit stray, input bit poke);
    bit            ok;
    int            last;
    logic [DW-1:0] exp_rdata;
    ok        = (ack_at >= 2) && (ack_at <= int'(T));
    last      = ok ? ack_at : int'(T);
    exp_rdata = (ok && !we) ? rd : '0;
    cpu_req   = 1'b1;
    cpu_w_en  = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_sel   = sel;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      if (poke && c <= last) begin
        cpu_req   = 1'b1;
        cpu_w_en  = ~we;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_sel   = 4'($urandom);
      end else begin
        cpu_req = 1'b0;
      end
      dbus_ack    = (c == ack_at) || (stray && c == 1);
      dbus_r_data = (c == ack_at) ? rd : DW'($urandom);
      chk("req", dbus_req_o, 64'(c <= last));
      chk("ready", cpu_ready_o, 64'(c == last + 2));
      chk("rsp_valid", cpu_rsp_valid_o, 64'(c == last + 1));
      chk("w_en", dbus_w_en_o, (c <= last) ? 64'(we) : 64'(0));
      chk("addr", dbus_addr_o, addr);
      chk("wdata", dbus_w_data_o, wdata);
      chk("sel", dbus_sel_o, sel);
      if (c >= last + 1) begin
        chk("rdata", cpu_rdata_o, exp_rdata);
        chk("err", cpu_err_o, 64'(!ok));
      end
    end
    dbus_ack = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cpu_req     = 1'b0;
    cpu_w_en    = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cpu_sel     = '0;
    dbus_ack    = 1'b0;
    dbus_r_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    txn(1'b0, 32'h0200BFF8, 32'h0, 4'hF, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(1'b1, 32'h02004000, 32'h00001000, 4'hF, 2, 32'hCAFEF00D, 1'b0, 1'b0);
    txn(1'b0, 32'h10000004, 32'h0, 4'h3, 7, 32'hA5A5_5A5A, 1'b0, 1'b1);
    txn(1'b0, 32'h10000008, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    txn(1'b0, 32'h1000000C, 32'h0, 4'hF, 3, 32'h0BAD_F00D, 1'b1, 1'b0);
    txn(1'b0, 32'h10000010, 32'h0, 4'hF, 16, 32'h12345678, 1'b0, 1'b0);
    txn(1'b1, 32'h10000014, 32'h55, 4'h1, 17, 32'h0, 1'b0, 1'b0);

    // Ack while idle must not start or complete anything
    dbus_ack = 1'b1;
    @(negedge clk);
    dbus_ack = 1'b0;
    chk("idle_ack_req", dbus_req_o, 0);
    chk("idle_ack_ready", cpu_ready_o, 1);
    chk("idle_ack_rsp", cpu_rsp_valid_o, 0);

    // Reset in REQ cycle 3 abandons the transaction
    cpu_req   = 1'b1;
    cpu_w_en  = 1'b1;
    cpu_addr  = 32'h20000000;
    cpu_wdata = 32'h77;
    cpu_sel   = 4'hF;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("pre_rst_req", dbus_req_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp", cpu_rsp_valid_o, 0);
    txn(1'b0, 32'h20000004, 32'h0, 4'hF, 2, 32'h600DCAFE, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int a;
      a = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, 20));
      txn(1'($urandom), AW'($urandom), DW'($urandom), 4'($urandom), a, DW'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
